// File: rtl/regfile_wr_arb_pkg.sv
// Shared defaults and FSM state type for the register-file write arbiter.
// Imported by regfile_wr_arbiter and regfile_rr_arb2.
package regfile_wr_arb_pkg;
  localparam int DATA_W_DFLT = 4;
  localparam int ADDR_W_DFLT = 5;
  localparam int DEPTH_DFLT  = 32;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  localparam logic PTR_R0 = 1'b0;
  localparam logic PTR_R1 = 1'b1;
endpackage

// File: rtl/regfile_rr_arb2.sv
// Two-way grant: one-hot grant from two requests, round-robin pointer or fixed R0 priority.
// Purely combinational; the pointer is owned by the caller.
module regfile_rr_arb2
  import regfile_wr_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_fixed,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      if (i_fixed || (i_ptr == PTR_R0)) o_gnt = 2'b01;
      else                              o_gnt = 2'b10;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two write requesters onto one registered register-file write port; 1-cycle latency.
// Macro REGFILE_WR_ARB_CLEAR_EN adds a DEPTH-entry zero-fill sweep (post-reset and on CLR_REQ).
module regfile_wr_arbiter
  import regfile_wr_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DEPTH  = DEPTH_DFLT
) (
  input  logic              UserCLK,
  input  logic              UserRST_N,
  input  logic [DATA_W-1:0] R0_D,
  input  logic [ADDR_W-1:0] R0_ADR,
  input  logic              R0_VALID,
  output logic              R0_READY,
  input  logic [DATA_W-1:0] R1_D,
  input  logic [ADDR_W-1:0] R1_ADR,
  input  logic              R1_VALID,
  output logic              R1_READY,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  input  logic              ConfigBits,
  output logic [DATA_W-1:0] D,
  output logic [ADDR_W-1:0] W_ADR,
  output logic              W_en
);

  logic              r_ptr;
  logic              r_wen;
  logic [DATA_W-1:0] r_d;
  logic [ADDR_W-1:0] r_adr;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_clr_wr;
  logic [ADDR_W-1:0] w_clr_adr;

  regfile_rr_arb2 u_arb (
    .i_req   ({R1_VALID, R0_VALID}),
    .i_fixed (ConfigBits),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt)
  );

`ifdef REGFILE_WR_ARB_CLEAR_EN
  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_sweep_last;

  assign w_sweep_last = (r_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge UserCLK or negedge UserRST_N) begin
    if (!UserRST_N) r_state <= ST_CLEAR;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:   if (CLR_REQ)      w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_sweep_last) w_state_nxt = ST_ARB;
    endcase
  end

  // Counter idles at zero in ARB so every sweep starts from entry 0.
  always_ff @(posedge UserCLK or negedge UserRST_N) begin
    if (!UserRST_N)                 r_cnt <= '0;
    else if (r_state != ST_CLEAR)   r_cnt <= '0;
    else if (w_sweep_last)          r_cnt <= '0;
    else                            r_cnt <= r_cnt + 1'b1;
  end

  assign w_arb_en  = (r_state == ST_ARB) && !CLR_REQ;
  assign CLR_BUSY  = (r_state == ST_CLEAR);
  assign w_clr_wr  = (r_state == ST_CLEAR);
  assign w_clr_adr = r_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = CLR_REQ;
  assign w_arb_en     = 1'b1;
  assign CLR_BUSY     = 1'b0;
  assign w_clr_wr     = 1'b0;
  assign w_clr_adr    = '0;
`endif

  assign R0_READY = w_gnt[0] && w_arb_en;
  assign R1_READY = w_gnt[1] && w_arb_en;
  assign w_xfer0  = R0_VALID && R0_READY;
  assign w_xfer1  = R1_VALID && R1_READY;

  always_ff @(posedge UserCLK or negedge UserRST_N) begin
    if (!UserRST_N) begin
      r_wen <= 1'b0;
      r_d   <= '0;
      r_adr <= '0;
    end else if (w_xfer0) begin
      r_wen <= 1'b1;
      r_d   <= R0_D;
      r_adr <= R0_ADR;
    end else if (w_xfer1) begin
      r_wen <= 1'b1;
      r_d   <= R1_D;
      r_adr <= R1_ADR;
    end else if (w_clr_wr) begin
      r_wen <= 1'b1;
      r_d   <= '0;
      r_adr <= w_clr_adr;
    end else begin
      r_wen <= 1'b0;
    end
  end

  // Pointer names the requester favoured on the next contended cycle; frozen in fixed mode.
  always_ff @(posedge UserCLK or negedge UserRST_N) begin
    if (!UserRST_N)                 r_ptr <= PTR_R0;
    else if (!ConfigBits && w_xfer0) r_ptr <= PTR_R1;
    else if (!ConfigBits && w_xfer1) r_ptr <= PTR_R0;
  end

  assign W_en  = r_wen;
  assign D     = r_d;
  assign W_ADR = r_adr;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic against a grant/write model.
// Clear-sweep scenarios follow REGFILE_WR_ARB_CLEAR_EN when it is defined.
module tb_regfile_wr_arbiter;
  localparam int DW  = 4;
  localparam int AW  = 5;
  localparam int DEP = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] r0_d, r1_d, d;
  logic [AW-1:0] r0_adr, r1_adr, w_adr;
  logic          r0_vld, r1_vld, r0_rdy, r1_rdy;
  logic          clr_req, clr_busy, cfg, w_en;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: favoured requester, expected write-port contents, expected grants.
  int            m_ptr;
  logic          m_wen;
  logic [DW-1:0] m_d;
  logic [AW-1:0] m_adr;
  logic          e_r0, e_r1;

  regfile_wr_arbiter dut (
    .UserCLK    (clk),
    .UserRST_N  (rst_n),
    .R0_D       (r0_d),
    .R0_ADR     (r0_adr),
    .R0_VALID   (r0_vld),
    .R0_READY   (r0_rdy),
    .R1_D       (r1_d),
    .R1_ADR     (r1_adr),
    .R1_VALID   (r1_vld),
    .R1_READY   (r1_rdy),
    .CLR_REQ    (clr_req),
    .CLR_BUSY   (clr_busy),
    .ConfigBits (cfg),
    .D          (d),
    .W_ADR      (w_adr),
    .W_en       (w_en)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ptr = 0;
    m_wen = 1'b0;
    m_d   = '0;
    m_adr = '0;
  endfunction

  function automatic void model_grant();
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (r0_vld && r1_vld) begin
      if (cfg || m_ptr == 0) e_r0 = 1'b1;
      else                   e_r1 = 1'b1;
    end else if (r0_vld) begin
      e_r0 = 1'b1;
    end else if (r1_vld) begin
      e_r1 = 1'b1;
    end
  endfunction

  function automatic void model_edge();
    if (e_r0) begin
      m_wen = 1'b1; m_d = r0_d; m_adr = r0_adr;
      if (!cfg) m_ptr = 1;
    end else if (e_r1) begin
      m_wen = 1'b1; m_d = r1_d; m_adr = r1_adr;
      if (!cfg) m_ptr = 0;
    end else begin
      m_wen = 1'b0;
    end
  endfunction

`ifdef REGFILE_WR_ARB_CLEAR_EN
  task automatic run_sweep(input string tag);
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      n_checks++;
      if (clr_busy !== 1'b1 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0)
        $display("FAIL %s_busy i=%0d: got busy=%b rdy=%b%b expected busy=1 rdy=00", tag, i, clr_busy, r0_rdy, r1_rdy);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (w_en !== 1'b1 || d !== '0 || w_adr !== AW'(i))
        $display("FAIL %s_wr i=%0d: got en=%b d=%h adr=%0d expected en=1 d=0 adr=%0d", tag, i, w_en, d, w_adr, i);
      else n_pass++;
    end
    m_wen = 1'b1; m_d = '0; m_adr = AW'(DEP - 1);
    @(negedge clk);
    n_checks++;
    if (clr_busy !== 1'b0)
      $display("FAIL %s_done: got busy=%b expected 0", tag, clr_busy);
    else n_pass++;
    @(posedge clk); #1;
    model_edge();
  endtask
`endif

  task automatic test_reset();
    r0_vld = 0; r1_vld = 0; r0_d = '0; r1_d = '0; r0_adr = '0; r1_adr = '0;
    clr_req = 0; cfg = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (w_en !== 1'b0 || d !== '0 || w_adr !== '0)
      $display("FAIL reset_out: got en=%b d=%h adr=%0d expected 0/0/0", w_en, d, w_adr);
    else n_pass++;
`ifdef REGFILE_WR_ARB_CLEAR_EN
    n_checks++;
    if (clr_busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", clr_busy);
    else n_pass++;
    rst_n = 1'b1;
    run_sweep("post_reset_sweep");
`else
    n_checks++;
    if (clr_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", clr_busy);
    else n_pass++;
    rst_n = 1'b1;
`endif
  endtask

  task automatic test_rr_alternate();
    logic [AW-1:0] exp_adr [4];
    logic [DW-1:0] exp_d   [4];
    exp_adr = '{5'd3, 5'd7, 5'd3, 5'd7};
    exp_d   = '{4'd5, 4'd9, 4'd5, 4'd9};
    cfg = 0;
    r0_vld = 1; r0_adr = 5'd3; r0_d = 4'd5;
    r1_vld = 1; r1_adr = 5'd7; r1_d = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (r0_rdy !== (i % 2 == 0) || r1_rdy !== (i % 2 == 1))
        $display("FAIL rr_ready i=%0d: got %b%b expected r0=%0d r1=%0d", i, r0_rdy, r1_rdy, i % 2 == 0, i % 2 == 1);
      else n_pass++;
      model_grant(); model_edge();
      @(posedge clk); #1;
      n_checks++;
      if (w_en !== 1'b1 || w_adr !== exp_adr[i] || d !== exp_d[i])
        $display("FAIL rr_write i=%0d: got en=%b adr=%0d d=%0d expected 1/%0d/%0d", i, w_en, w_adr, d, exp_adr[i], exp_d[i]);
      else n_pass++;
    end
    r0_vld = 0; r1_vld = 0;
  endtask

  task automatic test_fixed_priority();
    cfg = 1;
    r0_vld = 1; r0_adr = 5'd17; r0_d = 4'hC;
    r1_vld = 1; r1_adr = 5'd2;  r1_d = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0)
        $display("FAIL fixed_ready i=%0d: got %b%b expected r0=1 r1=0", i, r0_rdy, r1_rdy);
      else n_pass++;
      model_grant(); model_edge();
      @(posedge clk); #1;
      n_checks++;
      if (w_en !== 1'b1 || w_adr !== 5'd17 || d !== 4'hC)
        $display("FAIL fixed_write i=%0d: got en=%b adr=%0d d=%h expected 1/17/c", i, w_en, w_adr, d);
      else n_pass++;
    end
    r0_vld = 0; r1_vld = 0; cfg = 0;
  endtask

  task automatic test_same_addr();
    cfg = 0;
    r0_vld = 1; r0_adr = 5'd12; r0_d = 4'h1;
    r1_vld = 1; r1_adr = 5'd12; r1_d = 4'h2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      model_grant();
      n_checks++;
      if (r0_rdy !== e_r0 || r1_rdy !== e_r1)
        $display("FAIL same_addr_ready i=%0d: got %b%b expected %b%b", i, r0_rdy, r1_rdy, e_r0, e_r1);
      else n_pass++;
      model_edge();
      @(posedge clk); #1;
      n_checks++;
      if (w_en !== m_wen || w_adr !== m_adr || d !== m_d)
        $display("FAIL same_addr_write i=%0d: got en=%b adr=%0d d=%h expected %b/%0d/%h", i, w_en, w_adr, d, m_wen, m_adr, m_d);
      else n_pass++;
      if (e_r0) r0_vld = 0;
      if (e_r1) r1_vld = 0;
    end
    r0_vld = 0; r1_vld = 0;
  endtask

  task automatic test_clr();
`ifdef REGFILE_WR_ARB_CLEAR_EN
    r1_vld = 1; r1_adr = 5'd25; r1_d = 4'h6;
    clr_req = 1;
    @(negedge clk);
    n_checks++;
    if (r1_rdy !== 1'b0 || r0_rdy !== 1'b0)
      $display("FAIL clr_block: got rdy=%b%b expected 00", r0_rdy, r1_rdy);
    else n_pass++;
    @(posedge clk); #1;
    m_wen = 1'b0;
    clr_req = 0;
    run_sweep("clr_sweep");
    @(negedge clk);
    model_grant();
    n_checks++;
    if (r1_rdy !== 1'b1) $display("FAIL clr_after_ready: got %b expected 1", r1_rdy);
    else n_pass++;
    model_edge();
    @(posedge clk); #1;
    n_checks++;
    if (w_en !== 1'b1 || w_adr !== 5'd25 || d !== 4'h6)
      $display("FAIL clr_after_write: got en=%b adr=%0d d=%h expected 1/25/6", w_en, w_adr, d);
    else n_pass++;
    r1_vld = 0;
`else
    clr_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (clr_busy !== 1'b0) $display("FAIL clr_off_busy i=%0d: got %b expected 0", i, clr_busy);
      else n_pass++;
      model_grant(); model_edge();
      @(posedge clk); #1;
      n_checks++;
      if (w_en !== 1'b0) $display("FAIL clr_off_wen i=%0d: got %b expected 0", i, w_en);
      else n_pass++;
    end
    r1_vld = 1; r1_adr = 5'd25; r1_d = 4'h6;
    @(negedge clk);
    model_grant();
    n_checks++;
    if (r1_rdy !== 1'b1) $display("FAIL clr_off_ready: got %b expected 1", r1_rdy);
    else n_pass++;
    model_edge();
    @(posedge clk); #1;
    clr_req = 0; r1_vld = 0;
`endif
  endtask

  task automatic test_random();
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;
    cfg = 0;
    for (int c = 0; c < 300; c++) begin
      if (c % 25 == 0) cfg = 1'($urandom_range(0, 1));
      if (!r0_vld || acc0) begin
        r0_vld = ($urandom_range(0, 2) != 0);
        r0_d = DW'($urandom); r0_adr = AW'($urandom);
      end
      if (!r1_vld || acc1) begin
        r1_vld = ($urandom_range(0, 2) != 0);
        r1_d = DW'($urandom); r1_adr = AW'($urandom);
        if ($urandom_range(0, 4) == 0) r1_adr = r0_adr;
      end
      @(negedge clk);
      model_grant();
      n_checks++;
      if (r0_rdy !== e_r0 || r1_rdy !== e_r1)
        $display("FAIL rnd_ready c=%0d: got %b%b expected %b%b", c, r0_rdy, r1_rdy, e_r0, e_r1);
      else n_pass++;
      acc0 = e_r0; acc1 = e_r1;
      model_edge();
      @(posedge clk); #1;
      n_checks++;
      if (w_en !== m_wen || d !== m_d || w_adr !== m_adr)
        $display("FAIL rnd_write c=%0d: got en=%b d=%h adr=%0d expected %b/%h/%0d", c, w_en, d, w_adr, m_wen, m_d, m_adr);
      else n_pass++;
    end
    r0_vld = 0; r1_vld = 0; cfg = 0;
    @(posedge clk); #1;
    m_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg = 0;
    r0_vld = 1; r0_adr = 5'd21; r0_d = 4'hA;
    @(negedge clk);
    model_grant(); model_edge();
    @(posedge clk); #1;
    r1_vld = 1; r1_adr = 5'd9; r1_d = 4'h4;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_en !== 1'b0 || d !== '0 || w_adr !== '0)
      $display("FAIL mid_reset_out: got en=%b d=%h adr=%0d expected 0/0/0", w_en, d, w_adr);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef REGFILE_WR_ARB_CLEAR_EN
    run_sweep("mid_reset_sweep");
`endif
    @(negedge clk);
    model_grant();
    n_checks++;
    if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0)
      $display("FAIL mid_reset_ptr: got %b%b expected r0=1 r1=0", r0_rdy, r1_rdy);
    else n_pass++;
    model_edge();
    @(posedge clk); #1;
    n_checks++;
    if (w_en !== 1'b1 || w_adr !== 5'd21 || d !== 4'hA)
      $display("FAIL mid_reset_write: got en=%b adr=%0d d=%h expected 1/21/a", w_en, w_adr, d);
    else n_pass++;
    r0_vld = 0; r1_vld = 0;
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_fixed_priority();
    test_same_addr();
    test_clr();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 4, write-data width; ADDR_W, 5, address width; DEPTH, 32, entries swept by clear.
REQ-002 UserCLK  in  1  single clock, all state on rising edge.
REQ-003 UserRST_N  in  1  reset, asynchronous, active-low.
REQ-004 R0_D  in  DATA_W  requester 0 write data.
REQ-005 R0_ADR  in  ADDR_W  requester 0 write address.
REQ-006 R0_VALID  in  1  requester 0 write request.
REQ-007 R0_READY  out  1  requester 0 accept (combinational).
REQ-008 R1_D, R1_ADR, R1_VALID, R1_READY SHALL mirror REQ-004..007 for requester 1.
REQ-009 CLR_REQ  in  1  request zero-fill of all DEPTH entries.
REQ-010 CLR_BUSY  out  1  clear sweep in progress.
REQ-011 ConfigBits  in  1  0 = round-robin, 1 = fixed priority (R0 wins).
REQ-012 D  out  DATA_W  registered write data to register-file write port.
REQ-013 W_ADR  out  ADDR_W  registered write address.
REQ-014 W_en  out  1  registered write enable.

Function
REQ-015 FSM states SHALL be ARB and CLEAR.
REQ-016 Transfer SHALL occur when Rn_VALID and Rn_READY are both high on a rising edge.
REQ-017 In ARB with CLR_REQ low: one VALID -> that READY high; both VALID -> exactly one READY high per arbitration mode; no VALID -> both READY low.
REQ-018 Round-robin: pointer resets to R0; after each transfer, pointer moves to the other requester; pointer unchanged on idle cycles.
REQ-019 Fixed priority: R0 granted whenever R0_VALID high; pointer frozen.
REQ-020 Transfer at edge N SHALL drive W_en=1, D, and W_ADR from the winner during cycle N+1; no transfer -> W_en=0, D/W_ADR hold previous values.
REQ-021 Equal addresses from both requesters SHALL be serialised (two writes, grant order), never merged.
REQ-022 CLR_REQ high in ARB SHALL force both READY low that cycle; FSM enters CLEAR at that edge with counter 0.
REQ-023 In CLEAR: each cycle emit W_en=1, D=0, W_ADR=counter; counter increments; after DEPTH-1 written, return to ARB (counter wraps to 0).
REQ-024 In CLEAR, both READY low, CLR_BUSY high; CLR_REQ ignored (no restart, no extension).
REQ-025 Clear sweep SHALL last exactly DEPTH cycles of W_en=1.
REQ-026 Requesters hold VALID/D/ADR stable until accepted; the arbiter does not check this.

Reset
REQ-027 UserRST_N low SHALL asynchronously set W_en=0, D=0, W_ADR=0, RR pointer=R0, counter=0.
REQ-028 With the clear feature compiled in, reset state SHALL be CLEAR (CLR_BUSY=1, READY=0 during and after reset until sweep completes); otherwise ARB.
REQ-029 Reset asserted mid-sweep or mid-transfer SHALL abort it; no partial state survives.

Configuration
REQ-030 Macro REGFILE_WR_ARB_CLEAR_EN defined: CLEAR state, counter, CLR_REQ and post-reset sweep present.
REQ-031 Macro undefined: no CLEAR state or counter; CLR_REQ ignored; CLR_BUSY tied 0; FSM permanently ARB.

Structure
REQ-032 Package regfile_wr_arb_pkg SHALL hold DATA_W/ADDR_W/DEPTH defaults and the FSM state type.
REQ-033 Two-way grant logic SHALL be sub-module regfile_rr_arb2 (inputs two requests, mode, pointer; outputs one-hot grant).

Verification
REQ-034 Reset release (macro on) -> 32 cycles W_en=1, D=0, W_ADR 0..31, then CLR_BUSY=0, READY follows VALID.
REQ-035 RR, both VALID for 4 transfers (R0 A=3 D=5, R1 A=7 D=9) -> W_ADR sequence 3,7,3,7 with D 5,9,5,9, one cycle after each accept.
REQ-036 ConfigBits=1, both VALID 3 cycles -> R0 accepted 3 times, R1_READY low throughout.
REQ-037 CLR_REQ with R1_VALID high -> R1_READY low, next 32 cycles W_en=1, D=0; R1 accepted on first cycle after sweep.
REQ-038 UserRST_N pulsed at sweep address 10 -> outputs zero immediately; sweep restarts from 0 (macro on) or ARB (macro off).
REQ-039 Macro off, CLR_REQ high 5 cycles with no VALID -> W_en stays 0, CLR_BUSY 0.
